// File: rtl/cpu15_pkg.sv
// Shared constants for the cpu15 run-control logic: opcodes, sequencer states and phases.
package cpu15_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_HALT  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PH_FT = 2'd0,
    PH_DC = 2'd1,
    PH_EX = 2'd2,
    PH_WB = 2'd3
  } phase_e;

endpackage

// File: rtl/cpu15_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module cpu15_sat_cnt
  import cpu15_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] CNT
);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = &r_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                r_cnt <= '0;
    else if (CLR)             r_cnt <= '0;
    else if (INC && !w_full)  r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
  end

  assign CNT = r_cnt;

endmodule

// File: rtl/cpu15_seq_ctrl.sv
// cpu15 run-control sequencer: 4-phase one-hot stage enables, free-run/step/halt/breakpoint
// control and saturating cycle/instruction counters.
module cpu15_seq_ctrl
  import cpu15_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             CLR,
  input  logic             BRK_EN,
  input  logic [PC_W-1:0]  BRK_ADDR,
  input  logic [3:0]       OP_CODE,
  input  logic [PC_W-1:0]  P_COUNT,
  output logic             EN_FT,
  output logic             EN_DC,
  output logic             EN_EX,
  output logic             EN_WB,
  output logic [2:0]       STATE,
  output logic             HALTED,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_e r_state, w_state_nxt;
  phase_e r_phase;
  logic   r_step_q, r_run_q, r_hlt_seen;
  logic   w_active, w_step_edge, w_run_rise, w_wb_end, w_brk_hit;

  assign w_active    = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_step_edge = STEP && !r_step_q;
  assign w_run_rise  = RUN && !r_run_q;
  assign w_wb_end    = w_active && (r_phase == PH_WB);
  assign w_brk_hit   = BRK_EN && (P_COUNT == BRK_ADDR);

  // Enables decode registers only, so no combinational input-to-enable path exists.
  assign EN_FT  = w_active && (r_phase == PH_FT);
  assign EN_DC  = w_active && (r_phase == PH_DC);
  assign EN_EX  = w_active && (r_phase == PH_EX);
  assign EN_WB  = w_wb_end;
  assign STATE  = r_state;
  assign HALTED = (r_state == ST_HALT);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (RUN)              w_state_nxt = ST_RUN;
        else if (w_step_edge) w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (w_wb_end) begin
          if (r_hlt_seen)     w_state_nxt = ST_HALT;
          else if (w_brk_hit) w_state_nxt = ST_BREAK;
          else if (!RUN)      w_state_nxt = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (w_wb_end)         w_state_nxt = r_hlt_seen ? ST_HALT : ST_IDLE;
      end
      ST_HALT:                w_state_nxt = ST_HALT;
      ST_BREAK: begin
        // A held RUN must not resume from a breakpoint; only a fresh rising edge does.
        if (w_step_edge)      w_state_nxt = ST_STEP;
        else if (w_run_rise)  w_state_nxt = ST_RUN;
      end
      default:                w_state_nxt = ST_IDLE;
    endcase
    if (CLR) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_FT;
      r_step_q   <= 1'b0;
      r_run_q    <= 1'b0;
      r_hlt_seen <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step_q <= STEP;
      r_run_q  <= RUN;
      if (CLR || !w_active) r_phase <= PH_FT;
      else                  r_phase <= phase_e'(r_phase + 2'd1);
      if (CLR || w_wb_end)                r_hlt_seen <= 1'b0;
      else if (EN_EX && OP_CODE == OP_HLT) r_hlt_seen <= 1'b1;
    end
  end

  cpu15_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (CLR),
    .INC   (w_active),
    .CNT   (CYCLE_CNT)
  );

  cpu15_sat_cnt #(.W(CNT_W)) u_instr_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (CLR),
    .INC   (w_wb_end),
    .CNT   (INSTR_CNT)
  );

endmodule
